pll_lock_supervisor: RTL

//  Sequences the video PLL: pulses its reset, waits for lock with a timeout and bounded

---
 rtl/pll_sup_pkg.sv | 24 ++
 rtl/pll_lock_supervisor_sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the video PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int LOL_W = 8;

    localparam int DEF_RST_PULSE_CYC    = 32;
    localparam int DEF_LOCK_TIMEOUT_CYC = 5000000;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_MAX_RETRIES      = 3;
    localparam int DEF_CNT_W            = 23;

    function automatic logic [LOL_W-1:0] sat_inc(input logic [LOL_W-1:0] v);
        return (&v) ? v : v + LOL_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-stage synchronizer for a single asynchronous level, async-reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Video PLL bring-up: reset pulse, lock wait with bounded retries, lock debounce,
// then release of the pixel-domain reset. Loss of lock re-runs the sequence.
//
// state     | meaning
// PLL_RST   | PLL held in reset for RST_PULSE_CYC cycles
// WAIT_LOCK | PLL released, waiting for lock with timeout
// STABLE    | lock seen, debouncing for LOCK_STABLE_CYC cycles
// RUN       | locked and stable, core reset released
// FAIL      | retries exhausted, PLL held in reset until restart
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             restart_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [LOL_W-1:0] lol_count
);

    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [LOL_W-1:0] lol_q, lol_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lol_d   = lol_q;
        cnt_d   = (state_q inside {PLL_RST, WAIT_LOCK, STABLE}) ? cnt_q + CNT_W'(1) : '0;

        // restart wins over any lock or timeout event in the same cycle
        if (restart_req) begin
            state_d = PLL_RST;
            retry_d = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = (retry_d == RTY_MAX) ? FAIL : PLL_RST;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = PLL_RST;
                        lol_d   = sat_inc(lol_q);
                    end
                end
                FAIL:    state_d = FAIL;
                default: state_d = PLL_RST;
            endcase
        end

        if (restart_req || (state_d != state_q)) cnt_d = '0;

        // outputs follow the next state so they move on the same edge as the FSM
        pll_rst_d = (state_d == PLL_RST) || (state_d == FAIL);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            lol_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lol_q     <= lol_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign lol_count = lol_q;

endmodule
